dcache_wb_engine: RTL

Write-side AXI master engine sitting directly downstream of the data cache write port (wr_req/wr_type/wr_addr/wr_wstrb/wr_data/wr_rdy). It latches one write request at a time, either a 16-byte dirty-line write-back or an uncached single store, and drives the AXI AW/W/B channels. It also exposes the in-flight line address so the read path can hold back a conflicting refill until the write completes.

---
 rtl/dcache_wb_engine.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dcache_wb_engine.sv
// Data cache write-side AXI master engine.
// Accepts one write at a time: a dirty-line write-back (a LINE_BEATS-beat
// burst) or an uncached single store. It drives the AXI AW/W/B channels and
// publishes the in-flight line address so the read path can hold back a
// conflicting refill until the write has been acknowledged.
module dcache_wb_engine #(
    parameter logic [3:0] AXI_ID     = 4'd1,
    parameter int         LINE_BEATS = 4
) (
    input  logic         clk,
    input  logic         reset,
    // cache write port
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    // AXI write address channel
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,
    // AXI write data channel
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    // AXI write response channel
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready,
    // conflict tracking and completion
    output logic         pend_valid,
    output logic [27:0]  pend_addr,
    output logic         wr_done
);

    localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [2:0] TYPE_LINE = 3'b100;
    localparam logic [2:0] TYPE_WORD = 3'b010;
    localparam logic [2:0] TYPE_HALF = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2,
        S_B    = 2'd3
    } state_t;

    state_t             state_reg;
    logic [2:0]         type_reg;
    logic [31:0]        addr_reg;
    logic [3:0]         wstrb_reg;
    logic [127:0]       data_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               is_line;
    logic               last_beat;
    logic [31:0]        beat_words [LINE_BEATS];

    // Response id/code carry no information this engine acts on.
    logic               unused_b;
    assign unused_b = ^{bid, bresp};

    // Split the latched line into per-beat words; beat 0 is the low word.
    generate
        for (genvar gi = 0; gi < LINE_BEATS; gi++) begin : g_beat
            assign beat_words[gi] = data_reg[32*gi +: 32];
        end
    endgenerate

    assign is_line   = (type_reg == TYPE_LINE);
    assign last_beat = (cnt_reg == awlen[CNT_W-1:0]);

    // Channel fields are pure decodes of the registered request and state,
    // so they stay stable for as long as the handshake is stalled.
    assign wr_rdy     = (state_reg == S_IDLE);
    assign awid       = AXI_ID;
    assign awaddr     = is_line ? {addr_reg[31:4], 4'b0000} : addr_reg;
    assign awlen      = is_line ? 8'(LINE_BEATS - 1) : 8'd0;
    assign awsize     = is_line                  ? 3'd2 :
                        (type_reg == TYPE_WORD)  ? 3'd2 :
                        (type_reg == TYPE_HALF)  ? 3'd1 : 3'd0;
    assign awburst    = 2'b01;
    assign awlock     = 2'b00;
    assign awcache    = 4'h0;
    assign awprot     = 3'b000;
    assign awvalid    = (state_reg == S_AW);
    assign wid        = AXI_ID;
    assign wdata      = beat_words[cnt_reg];
    assign wstrb      = is_line ? 4'hF : wstrb_reg;
    assign wvalid     = (state_reg == S_W);
    assign wlast      = (state_reg == S_W) && last_beat;
    assign bready     = (state_reg == S_B);
    assign pend_valid = (state_reg != S_IDLE);
    assign pend_addr  = addr_reg[31:4];
    assign wr_done    = (state_reg == S_B) && bvalid;

    // Request latch, beat counter and channel sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            type_reg  <= '0;
            addr_reg  <= '0;
            wstrb_reg <= '0;
            data_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (wr_req) begin
                        type_reg  <= wr_type;
                        addr_reg  <= wr_addr;
                        wstrb_reg <= wr_wstrb;
                        data_reg  <= wr_data;
                        state_reg <= S_AW;
                    end
                end
                S_AW: begin
                    if (awready) begin
                        cnt_reg   <= '0;
                        state_reg <= S_W;
                    end
                end
                S_W: begin
                    if (wready) begin
                        if (last_beat) begin
                            cnt_reg   <= '0;
                            state_reg <= S_B;
                        end else begin
                            cnt_reg   <= cnt_reg + 1'b1;
                        end
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        // Pending address is dropped with the state so the
                        // read path sees the conflict window close cleanly.
                        addr_reg  <= '0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
